// File: rtl/hs32_bram_arb.sv
// hs32_bram_arb: two-master arbiter/sequencer in front of the BRAM controller.
// Ports: m0/m1 stb/ack request ports, o_* strobe port to controller, o_busy.
// Optional macro HS32_BRAM_ARB_RR_EN selects round-robin arbitration.
module hs32_bram_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [31:0]           i_m0_dwrite,
  input  logic                  i_m0_rw,
  input  logic                  i_m0_stb,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  output logic [31:0]           o_m0_dread,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [31:0]           i_m1_dwrite,
  input  logic                  i_m1_rw,
  input  logic                  i_m1_stb,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic [31:0]           o_m1_dread,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [31:0]           o_dwrite,
  output logic                  o_rw,
  output logic                  o_stb,
  input  logic                  i_ack,
  input  logic [31:0]           i_dread,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           dwrite_q, dwrite_d;
  logic                  rw_q, rw_d;
  logic                  gnt_q, gnt_d;
  logic                  err_q, err_d;
  logic [31:0]           m0_dread_q, m0_dread_d;
  logic [31:0]           m1_dread_q, m1_dread_d;
  logic                  sel;

`ifdef HS32_BRAM_ARB_RR_EN
  logic last_q, last_d;

  // On contention, grant whichever master was not granted last.
  always_comb begin
    sel = i_m1_stb & ~(i_m0_stb & last_q);
  end
`else
  always_comb begin
    sel = i_m1_stb & ~i_m0_stb;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dwrite_d   = dwrite_q;
    rw_d       = rw_q;
    gnt_d      = gnt_q;
    err_d      = err_q;
    m0_dread_d = m0_dread_q;
    m1_dread_d = m1_dread_q;
`ifdef HS32_BRAM_ARB_RR_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_m0_stb | i_m1_stb) begin
          addr_d   = sel ? i_m1_addr   : i_m0_addr;
          dwrite_d = sel ? i_m1_dwrite : i_m0_dwrite;
          rw_d     = sel ? i_m1_rw     : i_m0_rw;
          gnt_d    = sel;
          state_d  = S_ISSUE;
`ifdef HS32_BRAM_ARB_RR_EN
          last_d   = sel;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        err_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_ack) begin
          if (gnt_q) m1_dread_d = i_dread;
          else       m0_dread_d = i_dread;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          // Fires on the TIMEOUT-th wait cycle without an ack.
          if (cnt_d == TO_LIM) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      dwrite_q   <= 32'd0;
      rw_q       <= 1'b0;
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
      m0_dread_q <= 32'd0;
      m1_dread_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dwrite_q   <= dwrite_d;
      rw_q       <= rw_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      m0_dread_q <= m0_dread_d;
      m1_dread_q <= m1_dread_d;
    end
  end

`ifdef HS32_BRAM_ARB_RR_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`endif

  // All outputs decode straight from flops so reset clears them at once.
  assign o_stb      = (state_q == S_ISSUE);
  assign o_busy     = (state_q != S_IDLE);
  assign o_addr     = addr_q;
  assign o_dwrite   = dwrite_q;
  assign o_rw       = rw_q;
  assign o_m0_ack   = (state_q == S_RESP) & ~gnt_q;
  assign o_m1_ack   = (state_q == S_RESP) &  gnt_q;
  assign o_m0_err   = o_m0_ack & err_q;
  assign o_m1_err   = o_m1_ack & err_q;
  assign o_m0_dread = m0_dread_q;
  assign o_m1_dread = m1_dread_q;

endmodule

// File: tb/tb_hs32_bram_arb.sv
// tb_hs32_bram_arb: scoreboard bench for hs32_bram_arb.
// Directed transactions; a monitor pops expected acks as they appear.
`timescale 1ns/1ps
module tb_hs32_bram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] m0_addr, m1_addr, o_addr;
  logic [31:0] m0_dw, m1_dw, o_dwrite, i_dread;
  logic [31:0] m0_dr, m1_dr;
  logic        m0_rw, m1_rw, m0_stb, m1_stb;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        o_rw, o_stb, i_ack, o_busy;
  logic        ack_q, no_ack, spur;

  always #5 clk = ~clk;

  hs32_bram_arb #(.ADDR_WIDTH(12), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_addr(m0_addr), .i_m0_dwrite(m0_dw), .i_m0_rw(m0_rw),
    .i_m0_stb(m0_stb), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .o_m0_dread(m0_dr),
    .i_m1_addr(m1_addr), .i_m1_dwrite(m1_dw), .i_m1_rw(m1_rw),
    .i_m1_stb(m1_stb), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_m1_dread(m1_dr),
    .o_addr(o_addr), .o_dwrite(o_dwrite), .o_rw(o_rw), .o_stb(o_stb),
    .i_ack(i_ack), .i_dread(i_dread), .o_busy(o_busy)
  );

  // Controller model: acks one cycle after its strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= o_stb & ~no_ack;
  end
  assign i_ack   = ack_q | spur;
  assign i_dread = (o_addr == 12'h010) ? 32'hDEADBEEF
                                       : {20'hC0DE0, o_addr};

  typedef struct packed {
    logic        m;
    logic        err;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [11:0] a,
                       input logic [31:0] d, input logic rw);
    if (m) begin
      m1_addr = a; m1_dw = d; m1_rw = rw; m1_stb = 1'b1;
    end else begin
      m0_addr = a; m0_dw = d; m0_rw = rw; m0_stb = 1'b1;
    end
  endtask

  // Issue a request at a negedge, wait for its ack, return latency.
  task automatic run(input logic m, input logic [11:0] a,
                     input logic [31:0] d, input logic rw,
                     input logic e, input logic [31:0] xd,
                     output int n);
    exp_t x;
    x.m = m; x.err = e; x.d = xd;
    sb.push_back(x);
    drive(m, a, d, rw);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m ? m1_ack : m0_ack) && n < 40);
    if (m) m1_stb = 1'b0;
    else   m0_stb = 1'b0;
  endtask

  task automatic expect_ack(input logic m, input logic e,
                            input logic [31:0] xd);
    exp_t x;
    x.m = m; x.err = e; x.d = xd;
    sb.push_back(x);
  endtask

  initial begin
    int n, c0, c1, t0, t1;
    rst = 1'b1; no_ack = 1'b0; spur = 1'b0;
    m0_addr = '0; m0_dw = '0; m0_rw = 1'b0; m0_stb = 1'b0;
    m1_addr = '0; m1_dw = '0; m1_rw = 1'b0; m1_stb = 1'b0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (m0_ack || m1_ack) begin
          chk("ack_both", 32'(m0_ack & m1_ack), 32'd0);
          if (sb.size() == 0) begin
            chk("ack_unexpected", 32'(m1_ack), 32'd2);
          end else begin
            e = sb.pop_front();
            chk("ack_master", 32'(m1_ack), 32'(e.m));
            chk("ack_err", 32'(m1_ack ? m1_err : m0_err), 32'(e.err));
            chk("ack_dread", m1_ack ? m1_dr : m0_dr, e.d);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_stb", 32'(o_stb), 32'd0);
    chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    chk("rst_dread", m0_dr | m1_dr, 32'd0);
    chk("rst_oaddr", 32'(o_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single read on m0.
    expect_ack(1'b0, 1'b0, 32'hDEADBEEF);
    drive(1'b0, 12'h010, 32'h0, 1'b0);
    @(negedge clk);
    chk("rd_stb_issue", 32'(o_stb), 32'd1);
    chk("rd_oaddr", 32'(o_addr), 32'h010);
    @(negedge clk);
    chk("rd_stb_wait", 32'(o_stb), 32'd0);
    chk("rd_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    chk("rd_m0_ack", 32'(m0_ack), 32'd1);
    m0_stb = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", 32'(m0_ack), 32'd0);

    // Write passthrough on m1, held ISSUE..RESP.
    expect_ack(1'b1, 1'b0, 32'hC0DE0003);
    drive(1'b1, 12'h003, 32'h11223344, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_oaddr", 32'(o_addr), 32'h003);
      chk("wr_orw", 32'(o_rw), 32'd1);
      chk("wr_odw", o_dwrite, 32'h11223344);
    end
    chk("wr_m1_ack", 32'(m1_ack), 32'd1);
    chk("wr_m0_dr_kept", m0_dr, 32'hDEADBEEF);
    m1_stb = 1'b0;
    @(negedge clk);

    // Contention: both masters request continuously.
`ifdef HS32_BRAM_ARB_RR_EN
    t0 = 2; t1 = 2;
    expect_ack(1'b0, 1'b0, 32'hC0DE0020);
    expect_ack(1'b1, 1'b0, 32'hC0DE0030);
    expect_ack(1'b0, 1'b0, 32'hC0DE0020);
    expect_ack(1'b1, 1'b0, 32'hC0DE0030);
`else
    t0 = 4; t1 = 1;
    for (int i = 0; i < 4; i++) expect_ack(1'b0, 1'b0, 32'hC0DE0020);
    expect_ack(1'b1, 1'b0, 32'hC0DE0030);
`endif
    c0 = 0; c1 = 0;
    drive(1'b0, 12'h020, 32'h0, 1'b0);
    drive(1'b1, 12'h030, 32'h0, 1'b0);
    for (int i = 0; i < 80 && !(c0 == t0 && c1 == t1); i++) begin
      @(negedge clk);
      if (m0_ack) begin
        c0++;
        if (c0 == t0) m0_stb = 1'b0;
      end
      if (m1_ack) begin
        c1++;
        if (c1 == t1) m1_stb = 1'b0;
      end
    end
    chk("cont_m0_cnt", 32'(c0), 32'(t0));
    chk("cont_m1_cnt", 32'(c1), 32'(t1));
    m0_stb = 1'b0; m1_stb = 1'b0;
    @(negedge clk);

    // Timeout: controller never acks.
    no_ack = 1'b1;
    expect_ack(1'b0, 1'b1, 32'hC0DE0020);
    drive(1'b0, 12'h040, 32'h0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_stb && n < 5);
    chk("to_stb_seen", 32'(o_stb), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m0_ack && n < 40);
    chk("to_latency", 32'(n), 32'd16);
    chk("to_err", 32'(m0_err), 32'd1);
    m0_stb = 1'b0;
    no_ack = 1'b0;
    @(negedge clk);
    run(1'b0, 12'h060, 32'h0, 1'b0, 1'b0, 32'hC0DE0060, n);
    chk("after_to_lat", 32'(n), 32'd3);
    @(negedge clk);

    // Reset in WAIT.
    no_ack = 1'b1;
    drive(1'b0, 12'h070, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_in_wait", 32'(o_busy & ~o_stb), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", 32'(o_busy), 32'd0);
    chk("mid_stb", 32'(o_stb), 32'd0);
    chk("mid_acks", 32'({m0_ack, m1_ack}), 32'd0);
    chk("mid_dread", m0_dr, 32'd0);
    m0_stb = 1'b0;
    no_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1'b1, 12'h050, 32'h0, 1'b0, 1'b0, 32'hC0DE0050, n);
    chk("post_rst_lat", 32'(n), 32'd3);
    @(negedge clk);

    // Spurious ack while idle.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_idle", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("spur_idle2", 32'({o_busy, o_stb, m0_ack, m1_ack}), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
